// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FWFT FIFO.
package sync_fifo_pkg;

  // Memory inference styles; behaviour is identical for both.
  localparam string ArchXilinx  = "Xilinx";
  localparam string ArchGeneric = "Generic";

  // Ceiling log2, used to size addresses and pointers at elaboration time.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous (combinational) read.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 128,
  parameter string       ARCH  = ArchXilinx,
  localparam int unsigned AddrW = clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  if (ARCH == ArchXilinx) begin : g_xilinx
    // Distributed RAM keeps the read path asynchronous, as FWFT needs.
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
    end

    assign rd_data_o = mem_q[rd_addr_i];
  end else begin : g_generic
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
    end

    assign rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty status and
// one-cycle overflow/underflow error pulses.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 128,
  parameter string       ARCH  = ArchXilinx
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_wr_en,
  output logic             o_full,
  output logic             o_wr_err,
  input  logic             i_rd_incr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_rd_err
);

  localparam int unsigned AddrW = clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  // MSB of each pointer is the wrap bit; lower bits index the memory.
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            wr_err_q, wr_err_d;
  logic            rd_err_q, rd_err_d;

  logic empty, full;
  logic wr_accept, rd_accept;
  logic mem_wr_en;

  // Status, acceptance and next-state computation
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
            (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);

    rd_accept = i_rd_incr && !empty;
    // A pop in the same cycle frees a slot, so a write at full still goes in.
    wr_accept = i_wr_en && (!full || rd_accept);

    wr_ptr_d = wr_accept ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = rd_accept ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_err_d = i_wr_en && !wr_accept;
    rd_err_d = i_rd_incr && !rd_accept;

    // Reset takes precedence, so no memory write while it is asserted.
    mem_wr_en = wr_accept && i_rst;
  end

  // Pointer and error-flag registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ARCH  (ARCH)
  ) u_ram (
    .clk_i     (i_clk),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (wr_ptr_q[AddrW-1:0]),
    .wr_data_i (i_data),
    .rd_addr_i (rd_ptr_q[AddrW-1:0]),
    .rd_data_o (o_data)
  );

  assign o_empty  = empty;
  assign o_full   = full;
  assign o_wr_err = wr_err_q;
  assign o_rd_err = rd_err_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (WIDTH=19, DEPTH=128).
module tb_sync_fifo;

  localparam int unsigned WIDTH = 19;
  localparam int unsigned DEPTH = 128;

  logic             i_clk;
  logic             i_rst;
  logic [WIDTH-1:0] i_data;
  logic             i_wr_en;
  logic             o_full;
  logic             o_wr_err;
  logic             i_rd_incr;
  logic [WIDTH-1:0] o_data;
  logic             o_empty;
  logic             o_rd_err;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] v;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ARCH  ("Xilinx")
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_wr_en   (i_wr_en),
    .o_full    (o_full),
    .o_wr_err  (o_wr_err),
    .i_rd_incr (i_rd_incr),
    .o_data    (o_data),
    .o_empty   (o_empty),
    .o_rd_err  (o_rd_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst     = 1'b0;
    i_data    = '0;
    i_wr_en   = 1'b0;
    i_rd_incr = 1'b0;

    // Reset for 10 cycles, then release
    repeat (10) step();
    i_rst = 1'b1;
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_wr_err", 32'(o_wr_err), 32'd0);
    chk("rst_rd_err", 32'(o_rd_err), 32'd0);

    // Push 0..63, then pop in order
    for (int i = 0; i < 64; i++) begin
      i_wr_en = 1'b1;
      i_data  = 19'(i);
      step();
      if (i == 0) begin
        chk("fwft_first_empty", 32'(o_empty), 32'd0);
        chk("fwft_first_data", 32'(o_data), 32'd0);
      end
    end
    i_wr_en = 1'b0;
    chk("h64_empty", 32'(o_empty), 32'd0);
    chk("h64_full", 32'(o_full), 32'd0);
    chk("h64_data", 32'(o_data), 32'd0);
    for (int i = 0; i < 64; i++) begin
      chk("pop64_data", 32'(o_data), 32'(i));
      i_rd_incr = 1'b1;
      step();
    end
    i_rd_incr = 1'b0;
    chk("pop64_empty", 32'(o_empty), 32'd1);

    // Fill to 128, then overflow attempt
    for (int i = 0; i < 128; i++) begin
      i_wr_en = 1'b1;
      i_data  = 19'(i + 100);
      step();
      if (i == 126) chk("full_at_127", 32'(o_full), 32'd0);
    end
    chk("full_at_128", 32'(o_full), 32'd1);
    i_data = 19'h5A5A5;
    step();
    i_wr_en = 1'b0;
    chk("ovf_wr_err", 32'(o_wr_err), 32'd1);
    chk("ovf_full", 32'(o_full), 32'd1);
    chk("ovf_head", 32'(o_data), 32'd100);
    step();
    chk("ovf_wr_err_clr", 32'(o_wr_err), 32'd0);
    for (int i = 0; i < 128; i++) begin
      chk("pop128_data", 32'(o_data), 32'(i + 100));
      i_rd_incr = 1'b1;
      step();
      if (i == 0) chk("pop128_not_full", 32'(o_full), 32'd0);
    end
    i_rd_incr = 1'b0;
    chk("pop128_empty", 32'(o_empty), 32'd1);

    // Underflow
    i_rd_incr = 1'b1;
    step();
    i_rd_incr = 1'b0;
    chk("udf_rd_err", 32'(o_rd_err), 32'd1);
    chk("udf_empty", 32'(o_empty), 32'd1);
    step();
    chk("udf_rd_err_clr", 32'(o_rd_err), 32'd0);
    chk("udf_empty2", 32'(o_empty), 32'd1);

    // Simultaneous push/pop while empty: write in, read rejected
    i_wr_en   = 1'b1;
    i_rd_incr = 1'b1;
    i_data    = 19'h12345;
    step();
    i_wr_en   = 1'b0;
    i_rd_incr = 1'b0;
    chk("e_rw_rd_err", 32'(o_rd_err), 32'd1);
    chk("e_rw_empty", 32'(o_empty), 32'd0);
    chk("e_rw_data", 32'(o_data), 32'h12345);
    i_rd_incr = 1'b1;
    step();
    i_rd_incr = 1'b0;
    chk("e_rw_drain", 32'(o_empty), 32'd1);
    chk("e_rw_rd_err_clr", 32'(o_rd_err), 32'd0);

    // Half full, 300 cycles of push+pop across pointer wrap
    for (int i = 0; i < 64; i++) begin
      v = 19'(2000 + i);
      i_wr_en = 1'b1;
      i_data  = v;
      q.push_back(v);
      step();
    end
    for (int n = 0; n < 300; n++) begin
      chk("hf_data", 32'(o_data), 32'(q[0]));
      v = 19'(5000 + n);
      i_wr_en   = 1'b1;
      i_rd_incr = 1'b1;
      i_data    = v;
      void'(q.pop_front());
      q.push_back(v);
      step();
      chk("hf_empty", 32'(o_empty), 32'd0);
      chk("hf_full", 32'(o_full), 32'd0);
      chk("hf_errs", 32'({o_wr_err, o_rd_err}), 32'd0);
    end
    i_wr_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk("hf_drain_data", 32'(o_data), 32'(q[0]));
      chk("hf_drain_nonempty", 32'(o_empty), 32'd0);
      void'(q.pop_front());
      i_rd_incr = 1'b1;
      step();
    end
    i_rd_incr = 1'b0;
    chk("hf_drain_empty", 32'(o_empty), 32'd1);

    // Full, push+pop accepted and stays full
    for (int i = 0; i < 128; i++) begin
      v = 19'(30000 + i * 3);
      i_wr_en = 1'b1;
      i_data  = v;
      q.push_back(v);
      step();
    end
    chk("ff_full", 32'(o_full), 32'd1);
    for (int n = 0; n < 20; n++) begin
      chk("ff_data", 32'(o_data), 32'(q[0]));
      v = 19'(7000 + n);
      i_wr_en   = 1'b1;
      i_rd_incr = 1'b1;
      i_data    = v;
      void'(q.pop_front());
      q.push_back(v);
      step();
      chk("ff_still_full", 32'(o_full), 32'd1);
      chk("ff_errs", 32'({o_wr_err, o_rd_err}), 32'd0);
    end
    i_wr_en = 1'b0;
    for (int i = 0; i < 128; i++) begin
      chk("ff_drain_data", 32'(o_data), 32'(q[0]));
      void'(q.pop_front());
      i_rd_incr = 1'b1;
      step();
    end
    i_rd_incr = 1'b0;
    chk("ff_drain_empty", 32'(o_empty), 32'd1);

    // Fill 10, reset mid-operation (with a push pending), then new push
    for (int i = 0; i < 10; i++) begin
      i_wr_en = 1'b1;
      i_data  = 19'(i + 1);
      step();
    end
    i_rst = 1'b0;
    i_data = 19'h00ABC;
    step();
    i_rst   = 1'b1;
    i_wr_en = 1'b0;
    chk("mrst_empty", 32'(o_empty), 32'd1);
    chk("mrst_full", 32'(o_full), 32'd0);
    chk("mrst_errs", 32'({o_wr_err, o_rd_err}), 32'd0);
    i_wr_en = 1'b1;
    i_data  = 19'h7FFFF;
    step();
    i_wr_en = 1'b0;
    chk("post_rst_data", 32'(o_data), 32'h7FFFF);
    chk("post_rst_empty", 32'(o_empty), 32'd0);
    i_rd_incr = 1'b1;
    step();
    i_rd_incr = 1'b0;
    chk("post_rst_single", 32'(o_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
